// File: rtl/imem_loader.sv
// imem_loader
//   Downloads a program into the instruction memory before execution.
//   Bytes from the debug UART receiver are packed MSB first into 32-bit
//   words. Each word is written at the next address. Loading stops after
//   the HALT word has been written. It also stops with an error if the
//   memory fills up or the byte stream stalls in the middle of a word.
//   Outside loading, the memory address follows the pipeline PC.
//
// Ports
//   clk         in   clock, posedge
//   rst         in   asynchronous active-high reset
//   load_start  in   1-cycle pulse, (re)start download at address 0
//   rx_data     in   [7:0] received byte
//   rx_valid    in   1-cycle strobe qualifying rx_data
//   pc_addr     in   [31:0] pipeline PC word address
//   imem_wr     out  instruction memory write enable
//   imem_wdata  out  [31:0] word being written
//   imem_addr   out  [31:0] write pointer while loading, else pc_addr
//   loading     out  high in RECV/WRITE (pipeline held)
//   load_done   out  high in DONE
//   load_err    out  high in ERROR
//   word_count  out  [ADDR_W:0] words written in current/last download
module imem_loader #(
  parameter int          DEPTH       = 32,
  parameter int          ADDR_W      = 5,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [31:0]       pc_addr,
  output logic              imem_wr,
  output logic [31:0]       imem_wdata,
  output logic [31:0]       imem_addr,
  output logic              loading,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  // Error fires on the edge where the idle count would reach TIMEOUT_CYC.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  // Only the three most recent bytes are kept; the fourth comes straight
  // from rx_data when the word is completed.
  logic [23:0]         asm_q, asm_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     count_q, count_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      byte_cnt_q <= '0;
      idle_q     <= '0;
      asm_q      <= '0;
      wdata_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      byte_cnt_q <= byte_cnt_d;
      idle_q     <= idle_d;
      asm_q      <= asm_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = S_RECV;
    end else begin
      case (state_q)
        S_RECV: begin
          if (rx_valid && (byte_cnt_q == 2'd3))
            state_d = S_WRITE;
          else if (!rx_valid && (byte_cnt_q != 2'd0) && (idle_q == IDLE_LAST))
            state_d = S_ERROR;
        end
        S_WRITE: begin
          if (wdata_q == HALT_WORD)
            state_d = S_DONE;
          else if (wptr_q == PTR_LAST)
            state_d = S_ERROR;
          else
            state_d = S_RECV;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath next values
  always_comb begin
    wptr_d     = wptr_q;
    byte_cnt_d = byte_cnt_q;
    idle_d     = idle_q;
    asm_d      = asm_q;
    wdata_d    = wdata_q;
    count_d    = count_q;
    if (load_start) begin
      // A write in progress still happens (imem_wr is decoded from
      // state), but the pointer and count restart from zero.
      wptr_d     = '0;
      byte_cnt_d = '0;
      idle_d     = '0;
      count_d    = '0;
    end else begin
      case (state_q)
        S_RECV: begin
          if (rx_valid) begin
            asm_d      = {asm_q[15:0], rx_data};
            byte_cnt_d = byte_cnt_q + 2'd1;  // wraps to 0 on the 4th byte
            idle_d     = '0;
            if (byte_cnt_q == 2'd3)
              wdata_d = {asm_q, rx_data};
          end else if (byte_cnt_q != 2'd0) begin
            idle_d = idle_q + IDLE_ONE;
          end
        end
        S_WRITE: begin
          wptr_d  = wptr_q + PTR_ONE;
          count_d = count_q + CNT_ONE;
          // A byte arriving during the write starts the next word.
          if (rx_valid && (state_d == S_RECV)) begin
            asm_d      = {asm_q[15:0], rx_data};
            byte_cnt_d = 2'd1;
            idle_d     = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    imem_wr    = (state_q == S_WRITE);
    loading    = (state_q == S_RECV) || (state_q == S_WRITE);
    load_done  = (state_q == S_DONE);
    load_err   = (state_q == S_ERROR);
    imem_wdata = wdata_q;
    word_count = count_q;
    imem_addr  = loading ? {{(32 - ADDR_W){1'b0}}, wptr_q} : pc_addr;
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [31:0]       pc_addr;
  logic              imem_wr;
  logic [31:0]       imem_wdata;
  logic [31:0]       imem_addr;
  logic              loading;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   word_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  imem_loader #(
    .DEPTH(32), .ADDR_W(ADDR_W), .HALT_WORD(32'hFFFF_FFFF), .TIMEOUT_CYC(10)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .rx_data(rx_data),
    .rx_valid(rx_valid), .pc_addr(pc_addr), .imem_wr(imem_wr),
    .imem_wdata(imem_wdata), .imem_addr(imem_addr), .loading(loading),
    .load_done(load_done), .load_err(load_err), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side monitor: record every write as the memory would see it.
  always @(negedge clk) begin
    if (imem_wr === 1'b1) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
      wc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [31:0] ea, input logic [31:0] ed);
    if (wa_q.size() > idx) begin
      chk({tag, "_addr"}, wa_q[idx], ea);
      chk({tag, "_data"}, wd_q[idx], ed);
    end else begin
      chk({tag, "_present"}, 32'(wa_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  // Called at a negedge; returns at the next negedge. Consecutive calls
  // give back-to-back valid bytes.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(t[31:24]);
      t = t << 8;
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    pc_addr    = 32'd7;

    // 1: reset state
    repeat (2) @(negedge clk);
    chk("t1_imem_wr", {31'b0, imem_wr}, 32'd0);
    chk("t1_wdata", imem_wdata, 32'd0);
    chk("t1_loading", {31'b0, loading}, 32'd0);
    chk("t1_done", {31'b0, load_done}, 32'd0);
    chk("t1_err", {31'b0, load_err}, 32'd0);
    chk("t1_count", 32'(word_count), 32'd0);
    chk("t1_addr", imem_addr, 32'd7);
    rst = 1'b0;
    @(negedge clk);

    // 2: two-word program ending in HALT, with a gap between bytes
    clear_log();
    start_load();
    chk("t2_loading", {31'b0, loading}, 32'd1);
    chk("t2_addr_wptr", imem_addr, 32'd0);
    send_byte(8'h12); @(negedge clk);
    send_byte(8'h34); @(negedge clk);
    send_byte(8'h56); @(negedge clk);
    send_byte(8'h78); @(negedge clk);
    send_word(32'hFFFF_FFFF);
    for (int k = 0; k < 50 && !load_done; k++) @(negedge clk);
    chk("t2_done", {31'b0, load_done}, 32'd1);
    chk("t2_count", 32'(word_count), 32'd2);
    chk("t2_nwr", 32'(wa_q.size()), 32'd2);
    chk_wr("t2_w0", 0, 32'd0, 32'h1234_5678);
    chk_wr("t2_w1", 1, 32'd1, 32'hFFFF_FFFF);
    chk("t2_loading_lo", {31'b0, loading}, 32'd0);
    pc_addr = 32'h0000_1234;
    #1;
    chk("t2_addr_pc", imem_addr, 32'h0000_1234);
    send_byte(8'hAB);
    chk("t2_done_hold", {31'b0, load_done}, 32'd1);

    // 3: overflow after 32 non-HALT words
    clear_log();
    start_load();
    for (int w = 0; w < 32; w++) send_word(32'hA500_0000 + 32'(w));
    for (int k = 0; k < 50 && !load_err; k++) @(negedge clk);
    chk("t3_err", {31'b0, load_err}, 32'd1);
    chk("t3_done", {31'b0, load_done}, 32'd0);
    chk("t3_count", 32'(word_count), 32'd32);
    chk("t3_nwr", 32'(wa_q.size()), 32'd32);
    for (int w = 0; w < 32; w++)
      chk_wr($sformatf("t3_w%0d", w), w, 32'(w), 32'hA500_0000 + 32'(w));

    // 4: stall mid-word -> error exactly 10 cycles after the last byte
    clear_log();
    start_load();
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (9) @(negedge clk);
    chk("t4_err_early", {31'b0, load_err}, 32'd0);
    @(negedge clk);
    chk("t4_err", {31'b0, load_err}, 32'd1);
    chk("t4_nwr", 32'(wa_q.size()), 32'd0);

    // 5: bytes every cycle, two words, byte during WRITE not lost
    clear_log();
    start_load();
    for (int b = 1; b <= 8; b++) send_byte(8'(b));
    repeat (3) @(negedge clk);
    chk("t5_nwr", 32'(wa_q.size()), 32'd2);
    chk_wr("t5_w0", 0, 32'd0, 32'h0102_0304);
    chk_wr("t5_w1", 1, 32'd1, 32'h0506_0708);
    if (wc_q.size() == 2) chk("t5_spacing", 32'(wc_q[1] - wc_q[0]), 32'd4);
    else chk("t5_spacing_n", 32'(wc_q.size()), 32'd2);
    chk("t5_count", 32'(word_count), 32'd2);
    chk("t5_loading", {31'b0, loading}, 32'd1);

    // 6: asynchronous reset mid-word, then a fresh one-word load
    clear_log();
    send_byte(8'h11);
    send_byte(8'h22);
    pc_addr = 32'h0000_0042;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_loading", {31'b0, loading}, 32'd0);
    chk("t6_rst_count", 32'(word_count), 32'd0);
    chk("t6_rst_addr", imem_addr, 32'h0000_0042);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_load();
    send_word(32'hFFFF_FFFF);
    for (int k = 0; k < 50 && !load_done; k++) @(negedge clk);
    chk("t6_done", {31'b0, load_done}, 32'd1);
    chk("t6_count", 32'(word_count), 32'd1);
    chk("t6_nwr", 32'(wa_q.size()), 32'd1);
    chk_wr("t6_w0", 0, 32'd0, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
